// File: rtl/spio_spinn2aer_filter_if.sv
// rtl/spio_spinn2aer_filter_if.sv - packet in/out handshake bundle for the SpiNNaker-to-AER filter
interface spio_spinn2aer_filter_if;
    logic [71:0] ipkt_data;
    logic        ipkt_vld;
    logic        ipkt_rdy;
    logic [71:0] opkt_data;
    logic        opkt_vld;
    logic        opkt_rdy;

    modport slave (
        input  ipkt_data,
        input  ipkt_vld,
        output ipkt_rdy,
        output opkt_data,
        output opkt_vld,
        input  opkt_rdy
    );

    modport master (
        output ipkt_data,
        output ipkt_vld,
        input  ipkt_rdy,
        input  opkt_data,
        input  opkt_vld,
        output opkt_rdy
    );
endinterface

// File: rtl/spio_spinn2aer_filter.sv
// rtl/spio_spinn2aer_filter.sv - multicast key/mask filter with FIFO and registered head stage
// Optional odd-parity check enabled by defining SPIO_FILTER_PARITY_CHK_EN.
module spio_spinn2aer_filter #(
    parameter int FIFO_AW  = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    spio_spinn2aer_filter_if.slave pkt,
    input  logic [31:0]         filter_key,
    input  logic [31:0]         filter_mask,
    output logic [CNT_BITS-1:0] drop_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = DEPTH[FIFO_AW:0];

    logic [71:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    fifo_cnt_q, fifo_cnt_d;
    logic [71:0]         head_data_q, head_data_d;
    logic                head_vld_q, head_vld_d;
    logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

    logic parity_ok;
    logic key_match;
    logic pass;
    logic accept;
    logic pop;
    logic head_direct;
    logic refill;
    logic fifo_wr;

`ifdef SPIO_FILTER_PARITY_CHK_EN
    assign parity_ok = ^pkt.ipkt_data;
`else
    assign parity_ok = 1'b1;
`endif

    // Ready is a pure function of registered state so the mapper's rdy never
    // reaches back combinationally into the link receiver.
    assign pkt.ipkt_rdy = !((fifo_cnt_q == FULL_CNT) && head_vld_q);

    assign key_match   = ((pkt.ipkt_data[39:8] ^ filter_key) & filter_mask) == 32'h0;
    assign pass        = (pkt.ipkt_data[7:6] == 2'b00) && key_match && parity_ok;
    assign accept      = pkt.ipkt_vld && pkt.ipkt_rdy;
    assign pop         = head_vld_q && pkt.opkt_rdy;
    assign head_direct = accept && pass &&
                         (!head_vld_q || (pop && (fifo_cnt_q == '0)));
    assign refill      = pop && (fifo_cnt_q != '0);
    assign fifo_wr     = accept && pass && !head_direct;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        head_data_d = head_data_q;
        head_vld_d  = head_vld_q;
        drop_cnt_d  = drop_cnt_q;

        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (refill) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        if (fifo_wr && !refill) begin
            fifo_cnt_d = fifo_cnt_q + (FIFO_AW+1)'(1);
        end else if (refill && !fifo_wr) begin
            fifo_cnt_d = fifo_cnt_q - (FIFO_AW+1)'(1);
        end

        if (refill) begin
            head_data_d = mem_q[rd_ptr_q];
            head_vld_d  = 1'b1;
        end else if (head_direct) begin
            head_data_d = pkt.ipkt_data;
            head_vld_d  = 1'b1;
        end else if (pop) begin
            head_vld_d  = 1'b0;
        end

        if (accept && !pass && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            head_data_q <= '0;
            head_vld_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            head_data_q <= head_data_d;
            head_vld_q  <= head_vld_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage needs no reset: emptiness is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= pkt.ipkt_data;
        end
    end

    assign pkt.opkt_data = head_data_q;
    assign pkt.opkt_vld  = head_vld_q;
    assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_spio_spinn2aer_filter.sv
// tb/tb_spio_spinn2aer_filter.sv - scoreboard bench for spio_spinn2aer_filter
module tb_spio_spinn2aer_filter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fkey = 32'h0;
    logic [31:0] fmask = 32'h0;
    logic [15:0] drop_cnt;
    logic [15:0] exp_drop = '0;
    int          n_total = 0;
    int          n_bad = 0;
    logic [71:0] sb[$];

    spio_spinn2aer_filter_if bus ();

    spio_spinn2aer_filter #(.FIFO_AW(2), .CNT_BITS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pkt        (bus),
        .filter_key (fkey),
        .filter_mask(fmask),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_pass(input logic [71:0] p);
        logic ok;
        ok = (p[7:6] == 2'b00) && (((p[39:8] ^ fkey) & fmask) == 32'h0);
`ifdef SPIO_FILTER_PARITY_CHK_EN
        ok = ok && (^p);
`endif
        return ok;
    endfunction

    // Builds a packet with odd overall parity.
    function automatic logic [71:0] mk_pkt(input logic [1:0] t, input logic [31:0] key);
        logic [71:0] p;
        p = {32'($urandom()), key, t, 5'($urandom()), 1'b0};
        p[0] = ~(^p);
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.opkt_vld && bus.opkt_rdy) begin
                if (sb.size() == 0) check("unexpected_out", bus.opkt_data, 72'h0);
                else check("out_data", bus.opkt_data, sb.pop_front());
            end
            if (bus.ipkt_vld && bus.ipkt_rdy) begin
                if (model_pass(bus.ipkt_data)) sb.push_back(bus.ipkt_data);
                else if (exp_drop != '1) exp_drop++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [71:0] p);
        logic ok;
        ok = 1'b0;
        bus.ipkt_data = p;
        bus.ipkt_vld  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ipkt_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.ipkt_vld = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] p;
        logic [71:0] pk[6];
        logic [31:0] k;
        bit ok;

        bus.ipkt_data = '0;
        bus.ipkt_vld  = 1'b0;
        bus.opkt_rdy  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_ipkt_rdy", bus.ipkt_rdy, 1'b1);
        check("rst_opkt_vld", bus.opkt_vld, 1'b0);
        check("rst_opkt_data", bus.opkt_data, 72'h0);
        check("rst_drop_cnt", drop_cnt, 16'h0);

        fkey  = 32'h0000_1200;
        fmask = 32'hFFFF_FF00;
        bus.opkt_rdy = 1'b1;
        p = mk_pkt(2'b00, 32'h0000_1234);
        send(p);
        check("lat1_vld", bus.opkt_vld, 1'b1);
        check("lat1_data", bus.opkt_data, p);
        check("lat1_drop", drop_cnt, 16'h0);
        step();
        check("lat1_vld_clear", bus.opkt_vld, 1'b0);
        check("lat1_data_hold", bus.opkt_data, p);

        send(mk_pkt(2'b00, 32'h0000_1334));
        check("drop_key_vld", bus.opkt_vld, 1'b0);
        send(mk_pkt(2'b01, 32'h0000_1234));
        check("drop_type_vld", bus.opkt_vld, 1'b0);
        check("drop_cnt2", drop_cnt, 16'd2);

        bus.opkt_rdy = 1'b0;
        for (int i = 0; i < 6; i++) pk[i] = mk_pkt(2'b00, {24'h000012, 8'(i * 7)});
        for (int i = 0; i < 5; i++) send(pk[i]);
        check("full_rdy_low", bus.ipkt_rdy, 1'b0);
        bus.ipkt_data = pk[5];
        bus.ipkt_vld  = 1'b1;
        step();
        step();
        check("full_rdy_hold", bus.ipkt_rdy, 1'b0);
        bus.opkt_rdy = 1'b1;
        check("full_no_comb_reopen", bus.ipkt_rdy, 1'b0);
        for (int kk = 0; kk < 6; kk++) begin
            if (kk == 2) bus.ipkt_vld = 1'b0;
            check("full_b2b_vld", bus.opkt_vld, 1'b1);
            if (kk == 1) check("full_rdy_reopen", bus.ipkt_rdy, 1'b1);
            step();
        end
        check("full_drained", bus.opkt_vld, 1'b0);
        check("full_sb_empty", 72'(sb.size()), 72'd0);

        for (int i = 0; i < 10; i++) begin
            bus.ipkt_data = mk_pkt(2'b00, {24'h000012, 8'($urandom())});
            bus.ipkt_vld  = 1'b1;
            if (i >= 1) check("stream_no_bubble", bus.opkt_vld, 1'b1);
            step();
        end
        bus.ipkt_vld = 1'b0;
        check("stream_last_vld", bus.opkt_vld, 1'b1);
        step();
        check("stream_end_vld", bus.opkt_vld, 1'b0);

        for (int i = 0; i < 400; i++) begin
            k = ($urandom_range(0, 2) != 0) ? {24'h000012, 8'($urandom())} : $urandom();
            p = mk_pkt(($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00, k);
            if ($urandom_range(0, 7) == 0) p[0] = ~p[0];
            bus.ipkt_data = p;
            bus.ipkt_vld  = ($urandom_range(0, 3) != 0);
            bus.opkt_rdy  = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            step();
        end
        bus.ipkt_vld = 1'b0;
        bus.opkt_rdy = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (sb.size() == 0 && !bus.opkt_vld) begin
                ok = 1'b1;
                break;
            end
        end
        check("rand_drain", ok, 1'b1);
        check("rand_drop_cnt", drop_cnt, exp_drop);

        bus.opkt_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(mk_pkt(2'b00, 32'h0000_12A0));
        send(mk_pkt(2'b10, 32'h0000_12A0));
        check("pre_rst_vld", bus.opkt_vld, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", bus.opkt_vld, 1'b0);
        check("mid_rst_drop", drop_cnt, 16'h0);
        sb.delete();
        exp_drop = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        bus.opkt_rdy = 1'b1;
        send(mk_pkt(2'b00, 32'h0000_1201));
        send(mk_pkt(2'b00, 32'h0000_12FE));
        step();
        step();
        check("post_rst_sb_empty", 72'(sb.size()), 72'd0);
        check("post_rst_vld", bus.opkt_vld, 1'b0);
        check("post_rst_drop", drop_cnt, 16'h0);

`ifdef SPIO_FILTER_PARITY_CHK_EN
        p = mk_pkt(2'b00, 32'h0000_1234);
        p[0] = ~p[0];
        send(p);
        check("parity_vld", bus.opkt_vld, 1'b0);
        check("parity_drop", drop_cnt, 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
